// File: rtl/reverse_hex_collector.sv
// reverse_hex_collector: rebuilds a SIZE-bit word from a serial stream of
// 4-bit digits that arrive last-digit-first. The restored word is held on a
// valid/ready output until the consumer takes it.
// Optional build macro REVERSE_HEX_COLLECTOR_BYPASS_EN adds a rev_en input.
// rev_en is latched on the first digit of each word. When it is 0, digits are
// placed in arrival order instead of being reversed.
module reverse_hex_collector #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_nib,
`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
  input  logic            rev_en,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:SIZE-1] dout,
  output logic [7:0]      word_cnt
);

  localparam int NIB = SIZE / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pos;
  logic          acc_in;
  logic          acc_out;
  logic          last;
  logic          rev_cur;

  // A digit dropped by clr is never treated as accepted.
  assign acc_in  = in_valid & in_ready & ~clr;
  assign acc_out = out_valid & out_ready;
  assign last    = (cnt == CW'(NIB - 1));

`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
  logic rev_lat;
  // Digit 0 uses the live rev_en. Later digits use the value latched with digit 0.
  assign rev_cur = (cnt == '0) ? rev_en : rev_lat;
`else
  assign rev_cur = 1'b1;
`endif

  // Destination digit slot: reversed placement puts arrival k at slot NIB-1-k.
  assign pos = rev_cur ? (CW'(NIB - 1) - cnt) : cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, COLLECT: if (acc_in) state_nxt = last ? HOLD : COLLECT;
        HOLD:          if (acc_out) state_nxt = IDLE;
        default:       state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state; in_ready is forced low during reset
  always_comb begin
    in_ready  = rst_n & (state != HOLD);
    out_valid = (state == HOLD);
  end

  // Digit counter, word assembly and delivered-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dout     <= '0;
      word_cnt <= 8'd0;
`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
      rev_lat  <= 1'b1;
`endif
    end else begin
      if (acc_out) word_cnt <= word_cnt + 8'd1;
      if (clr) begin
        cnt <= '0;
      end else if (acc_in) begin
        cnt <= last ? '0 : cnt + CW'(1);
        for (int p = 0; p < NIB; p++) begin
          if (pos == CW'(p)) dout[4*p +: 4] <= in_nib;
        end
`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
        if (cnt == '0) rev_lat <= rev_en;
`endif
      end else if (acc_out) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reverse_hex_collector.sv
// Bench for reverse_hex_collector: directed scenarios plus randomized traffic,
// checked against a queue-based reference model every cycle.
module tb_reverse_hex_collector;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_nib = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:15] dout;
  logic [7:0]  word_cnt;

  logic        clr32 = 1'b0;
  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [3:0]  in_nib32 = 4'h0;
  logic        out_valid32;
  logic        out_ready32 = 1'b0;
  logic [0:31] dout32;
  logic [7:0]  word_cnt32;

`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
  logic rev_en = 1'b1;
`endif

  reverse_hex_collector #(.SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_nib(in_nib),
`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
    .rev_en(rev_en),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .word_cnt(word_cnt)
  );

  reverse_hex_collector #(.SIZE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr32), .in_valid(in_valid32),
    .in_ready(in_ready32), .in_nib(in_nib32),
`ifdef REVERSE_HEX_COLLECTOR_BYPASS_EN
    .rev_en(rev_en),
`endif
    .out_valid(out_valid32), .out_ready(out_ready32), .dout(dout32),
    .word_cnt(word_cnt32)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: digits of the current word in arrival order, plus the held word
  logic [3:0]  m_q[$];
  logic        m_held = 1'b0;
  logic [15:0] m_word = 16'h0;
  logic [7:0]  m_cnt = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held = 1'b0;
    m_cnt  = 8'd0;
  endtask

  // Arrival k lands in nibble k counted from the least significant end
  task automatic model_step();
    logic [15:0] w;
    if (m_held && out_ready) begin
      m_cnt  = m_cnt + 8'd1;
      m_held = 1'b0;
    end else if (!clr && in_valid && !m_held) begin
      m_q.push_back(in_nib);
      if (m_q.size() == NIB) begin
        w = 16'h0;
        for (int k = 0; k < NIB; k++) w = w | (16'(m_q[k]) << (4 * k));
        m_word = w;
        m_held = 1'b1;
        m_q.delete();
      end
    end
    if (clr) begin
      m_q.delete();
      m_held = 1'b0;
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(m_held));
    chk("in_ready", 32'(in_ready), 32'(!m_held));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    if (m_held) chk("dout", 32'(dout), 32'(m_word));
  endtask

  task automatic cycle(input logic v, input logic [3:0] n, input logic ordy, input logic c);
    @(negedge clk);
    in_valid = v; in_nib = n; out_ready = ordy; clr = c;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  logic [7:0] saved;

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    // d,c,b,a back-to-back -> abcd
    cycle(1, 4'hd, 1, 0); cycle(1, 4'hc, 1, 0);
    cycle(1, 4'hb, 1, 0); cycle(1, 4'ha, 0, 0);
    chk("t1_dout", 32'(dout), 32'h0000abcd);
    chk("t1_valid", 32'(out_valid), 32'd1);
    cycle(0, 4'h0, 1, 0);
    chk("t1_cnt", 32'(word_cnt), 32'd1);

    // gap after second digit, consumer stalls 5 cycles
    cycle(1, 4'hf, 0, 0); cycle(1, 4'he, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 4'h7, 0, 0);
    cycle(1, 4'hc, 0, 0); cycle(1, 4'ha, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4'h5, 0, 0);
    chk("t2_dout", 32'(dout), 32'h0000acef);
    chk("t2_cnt_held", 32'(word_cnt), 32'd1);
    cycle(0, 4'h0, 1, 0);
    chk("t2_cnt", 32'(word_cnt), 32'd2);

    // partial word aborted by clr
    cycle(1, 4'h1, 0, 0); cycle(1, 4'h2, 0, 0); cycle(1, 4'h9, 0, 1);
    cycle(1, 4'hd, 0, 0); cycle(1, 4'hc, 0, 0);
    cycle(1, 4'hb, 0, 0); cycle(1, 4'ha, 0, 0);
    chk("t3_dout", 32'(dout), 32'h0000abcd);
    cycle(0, 4'h0, 1, 0);
    chk("t3_cnt", 32'(word_cnt), 32'd3);

    // clr coinciding with an output handshake still counts the word
    cycle(1, 4'h4, 0, 0); cycle(1, 4'h3, 0, 0);
    cycle(1, 4'h2, 0, 0); cycle(1, 4'h1, 0, 0);
    chk("t4_dout", 32'(dout), 32'h00001234);
    cycle(0, 4'h0, 1, 1);
    chk("t4_cnt", 32'(word_cnt), 32'd4);
    chk("t4_valid", 32'(out_valid), 32'd0);

    // 256 zero words wrap the counter back to its starting value
    saved = word_cnt;
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < NIB; k++) cycle(1, 4'h0, 1, 0);
      cycle(0, 4'h0, 1, 0);
    end
    chk("t5_wrap", 32'(word_cnt), 32'(saved));

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0));

    // asynchronous reset in the middle of a word
    cycle(1, 4'h6, 0, 0); cycle(1, 4'h7, 0, 0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_word_cnt", 32'(word_cnt), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 4'h8, 0, 0); cycle(1, 4'h9, 0, 0);
    cycle(1, 4'h1, 0, 0); cycle(1, 4'h2, 0, 0);
    chk("t6_dout", 32'(dout), 32'h00002198);
    cycle(0, 4'h0, 1, 0);

    // SIZE=32 instance: digits 8..1 restore 12345678
    for (int d = 8; d >= 1; d--) begin
      @(negedge clk); in_valid32 = 1'b1; in_nib32 = 4'(d);
    end
    @(negedge clk); in_valid32 = 1'b0;
    chk("t7_valid", 32'(out_valid32), 32'd1);
    chk("t7_ready", 32'(in_ready32), 32'd0);
    chk("t7_dout", 32'(dout32), 32'h12345678);
    out_ready32 = 1'b1;
    @(negedge clk); out_ready32 = 1'b0;
    chk("t7_cnt", 32'(word_cnt32), 32'd1);
    chk("t7_released", 32'(out_valid32), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
